stump_bist_ctrl: RTL and testbench

STUMP_BIST_CTRL -- requirements
Module: stump_bist_ctrl

---
 rtl/stump_bist_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_stump_bist_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stump_bist_ctrl.sv
// -----------------------------------------------------------------------------
// stump_bist_ctrl
// STUMPS-style logic BIST controller. It drives three scan chains with
// pseudo-random patterns from a 16-bit LFSR and compacts the scan-out streams
// into a 32-bit MISR. A run is LOAD, then NUM_PATTERNS x (CAPTURE + SHIFT or
// UNLOAD). At the end the MISR contents are compared against GOLDEN.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle run request (honoured in IDLE/DONE only)
//   NbarT      out  1 = scan shift, 0 = normal/capture
//   ir_Si      out  scan-in bit, chain ir  (lfsr[0])
//   ac_Si      out  scan-in bit, chain ac  (lfsr[1])
//   pc_Si      out  scan-in bit, chain pc  (lfsr[2])
//   ir_So      in   scan-out bit, chain ir
//   ac_So      in   scan-out bit, chain ac
//   cntrl_So   in   scan-out bit, chain cntrl
//   busy       out  run in progress
//   done       out  run complete, held until next start or rst
//   pass       out  signature == GOLDEN, valid while done = 1
//   signature  out  current MISR contents
// -----------------------------------------------------------------------------
module stump_bist_ctrl #(
  parameter int          CHAIN_LEN    = 32,
  parameter int          NUM_PATTERNS = 64,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [31:0] GOLDEN       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        NbarT,
  output logic        ir_Si,
  output logic        ac_Si,
  output logic        pc_Si,
  input  logic        ir_So,
  input  logic        ac_So,
  input  logic        cntrl_So,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 16'hACE1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;

  localparam int SHIFT_W = $clog2(CHAIN_LEN);
  localparam int PAT_W   = $clog2(NUM_PATTERNS + 1);

  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0]   PAT_NUM    = PAT_W'(NUM_PATTERNS);

  localparam logic [31:0] MISR_POLY = 32'h0040_0007;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_SHIFT,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SHIFT_W-1:0] r_shift_cnt;
  logic [SHIFT_W-1:0] w_shift_next;
  logic [PAT_W-1:0]   r_pat_cnt;
  logic [PAT_W-1:0]   w_pat_next;
  logic [PAT_W-1:0]   w_pat_inc;
  logic [15:0]        r_lfsr;
  logic [15:0]        w_lfsr_next;
  logic [15:0]        w_lfsr_adv;
  logic [31:0]        r_misr;
  logic [31:0]        w_misr_next;
  logic [31:0]        w_misr_upd;
  logic               w_shift_last;

  logic               r_nbart;
  logic [2:0]         r_si;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               w_nbart_next;
  logic [2:0]         w_si_next;
  logic               w_busy_next;
  logic               w_done_next;
  logic               w_pass_next;

  assign w_lfsr_adv   = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_misr_upd   = (r_misr << 1) ^ (r_misr[31] ? MISR_POLY : 32'h0)
                      ^ {29'b0, ir_So, ac_So, cntrl_So};
  assign w_shift_last = (r_shift_cnt == SHIFT_LAST);
  assign w_pat_inc    = r_pat_cnt + 1'b1;

  // Next-state, counter, LFSR/MISR and next-output logic.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift_cnt;
    w_pat_next   = r_pat_cnt;
    w_lfsr_next  = r_lfsr;
    w_misr_next  = r_misr;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_LOAD;
          w_shift_next = '0;
          w_pat_next   = '0;
          w_lfsr_next  = SEED_EFF;
          w_misr_next  = 32'h0;
        end
      end
      S_LOAD: begin
        // Chain contents are unknown while the first pattern goes in, so the
        // MISR is left alone here.
        w_lfsr_next = w_lfsr_adv;
        if (w_shift_last) begin
          w_shift_next = '0;
          w_state_next = S_CAPTURE;
        end else begin
          w_shift_next = r_shift_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        w_pat_next = w_pat_inc;
        if (w_pat_inc < PAT_NUM) begin
          w_state_next = S_SHIFT;
        end else begin
          w_state_next = S_UNLOAD;
        end
      end
      S_SHIFT: begin
        w_lfsr_next = w_lfsr_adv;
        w_misr_next = w_misr_upd;
        if (w_shift_last) begin
          w_shift_next = '0;
          w_state_next = S_CAPTURE;
        end else begin
          w_shift_next = r_shift_cnt + 1'b1;
        end
      end
      S_UNLOAD: begin
        w_misr_next = w_misr_upd;
        if (w_shift_last) begin
          w_shift_next = '0;
          w_state_next = S_DONE;
        end else begin
          w_shift_next = r_shift_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Outputs are registered: compute the value belonging to the cycle being
    // entered. Scan-in shows the LFSR value that cycle starts with.
    w_nbart_next = (w_state_next == S_LOAD) || (w_state_next == S_SHIFT) ||
                   (w_state_next == S_UNLOAD);
    w_si_next    = ((w_state_next == S_LOAD) || (w_state_next == S_SHIFT)) ?
                   w_lfsr_next[2:0] : 3'b000;
    w_busy_next  = (w_state_next == S_LOAD) || (w_state_next == S_CAPTURE) ||
                   (w_state_next == S_SHIFT) || (w_state_next == S_UNLOAD);
    w_done_next  = (w_state_next == S_DONE);
    w_pass_next  = (w_state_next == S_DONE) && (w_misr_next == GOLDEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_lfsr      <= SEED_EFF;
      r_misr      <= 32'h0;
      r_nbart     <= 1'b0;
      r_si        <= 3'b000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift_cnt <= w_shift_next;
      r_pat_cnt   <= w_pat_next;
      r_lfsr      <= w_lfsr_next;
      r_misr      <= w_misr_next;
      r_nbart     <= w_nbart_next;
      r_si        <= w_si_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_pass      <= w_pass_next;
    end
  end

  assign NbarT     = r_nbart;
  assign ir_Si     = r_si[0];
  assign ac_Si     = r_si[1];
  assign pc_Si     = r_si[2];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_misr;

endmodule

// File: tb/tb_stump_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stump_bist_ctrl
// Two controllers share start and scan-out stimulus: a small configuration
// (4 cells, 2 patterns) and a larger one (8 cells, 5 patterns, zero seed) long
// enough to push data through MISR bit 31. A cycle-schedule model pushes the
// expected per-cycle outputs into one queue per instance when a run is
// started; they are popped and compared on each falling edge.
// -----------------------------------------------------------------------------
module tb_stump_bist_ctrl;

  localparam int H = 56;  // cycles observed per run (covers both runs + DONE hold)

  localparam int CL1 = 4;
  localparam int NP1 = 2;
  localparam int CL2 = 8;
  localparam int NP2 = 5;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        nbart;
    logic [2:0]  si;     // {pc, ac, ir}
    logic        pass;
    logic [31:0] sig;
  } exp_t;

  typedef struct {
    logic [2:0]  so;      // {ir_So, ac_So, cntrl_So}, constant over the run
    logic [31:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  so;

  logic        nbart1, ir1, ac1, pc1, busy1, done1, pass1;
  logic [31:0] sig1;
  logic        nbart2, ir2, ac2, pc2, busy2, done2, pass2;
  logic [31:0] sig2;

  int n_checks = 0;
  int n_errors = 0;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [2:0] so_seq [0:H];

  stump_bist_ctrl #(
    .CHAIN_LEN(CL1), .NUM_PATTERNS(NP1), .SEED(16'hACE1), .GOLDEN(32'h0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .NbarT(nbart1), .ir_Si(ir1), .ac_Si(ac1), .pc_Si(pc1),
    .ir_So(so[2]), .ac_So(so[1]), .cntrl_So(so[0]),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  stump_bist_ctrl #(
    .CHAIN_LEN(CL2), .NUM_PATTERNS(NP2), .SEED(16'h0000), .GOLDEN(32'h0)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .NbarT(nbart2), .ir_Si(ir2), .ac_Si(ac2), .pc_Si(pc2),
    .ir_So(so[2]), .ac_So(so[1]), .cntrl_So(so[0]),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [31:0] misr_upd(input logic [31:0] m, input logic [2:0] s);
    return (m << 1) ^ (m[31] ? 32'h0040_0007 : 32'h0) ^ {29'b0, s};
  endfunction

  // Expected outputs per cycle after the start edge. Phase schedule:
  // LOAD cl cycles, then np blocks of CAPTURE + cl cycles (SHIFT, last UNLOAD).
  task automatic model(input int which, input int cl, input int np,
                       input logic [15:0] seed, input logic [31:0] golden);
    logic [15:0] l;
    logic [31:0] m;
    exp_t        e;
    int          pos, k, r, ph;  // ph: 0 load, 1 capture, 2 shift, 3 unload, 4 done
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    m = 32'h0;
    for (int c = 0; c < H; c++) begin
      pos = c;
      if (pos < cl) begin
        ph = 0;
      end else begin
        pos = pos - cl;
        k = pos / (cl + 1);
        r = pos % (cl + 1);
        if (k >= np)          ph = 4;
        else if (r == 0)      ph = 1;
        else if (k < np - 1)  ph = 2;
        else                  ph = 3;
      end
      e.busy  = (ph != 4);
      e.done  = (ph == 4);
      e.nbart = (ph == 0) || (ph == 2) || (ph == 3);
      e.si    = ((ph == 0) || (ph == 2)) ? l[2:0] : 3'b000;
      e.sig   = m;
      e.pass  = (ph == 4) && (m == golden);
      if (which == 1) q1.push_back(e);
      else            q2.push_back(e);
      if ((ph == 0) || (ph == 2)) l = lfsr_adv(l);
      if ((ph == 2) || (ph == 3)) m = misr_upd(m, so_seq[c]);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, " dut1"}, {25'b0, nbart1, ir1, ac1, pc1, busy1, done1, pass1, sig1}, 64'h0);
    check({name, " dut2"}, {25'b0, nbart2, ir2, ac2, pc2, busy2, done2, pass2, sig2}, 64'h0);
  endtask

  // One run: start pulse, then H observed cycles. glitch_at pulses start in
  // that cycle; abort_at asserts rst at the start of that cycle and returns.
  task automatic run(input int run_id, input int glitch_at, input int abort_at);
    exp_t e;
    exp_t a;
    q1.delete();
    q2.delete();
    model(1, CL1, NP1, 16'hACE1, 32'h0);
    model(2, CL2, NP2, 16'h0000, 32'h0);
    @(posedge clk); #1;
    start = 1'b1;
    so    = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    so    = so_seq[0];
    for (int c = 0; c < H; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check($sformatf("abort reset c%0d", c), 64'h0, 64'h0 | {25'b0, nbart1, ir1, ac1, pc1, busy1, done1, pass1, sig1});
        check_reset($sformatf("abort reset2 c%0d", c));
        @(negedge clk);
        rst = 1'b0;
        so  = 3'b000;
        $display("run %0d aborted at cycle %0d", run_id, c);
        return;
      end
      if (c == glitch_at) start = 1'b1;
      @(negedge clk);
      a = '{busy1, done1, nbart1, {pc1, ac1, ir1}, pass1, sig1};
      if (q1.size() == 0) check($sformatf("dut1 q empty c%0d", c), 64'h1, 64'h0);
      else begin
        e = q1.pop_front();
        check($sformatf("dut1 c%0d", c), 64'(a), 64'(e));
      end
      a = '{busy2, done2, nbart2, {pc2, ac2, ir2}, pass2, sig2};
      if (q2.size() == 0) check($sformatf("dut2 q empty c%0d", c), 64'h1, 64'h0);
      else begin
        e = q2.pop_front();
        check($sformatf("dut2 c%0d", c), 64'(a), 64'(e));
      end
      @(posedge clk); #1;
      start = 1'b0;
      so    = so_seq[c + 1];
    end
    $display("run %0d sig1=%h pass1=%b sig2=%h pass2=%b", run_id, sig1, pass1, sig2, pass2);
  endtask

  vec_t vecs [0:5];

  initial begin
    vecs[0] = '{3'b000, 32'h0000_0000, 1'b1};
    vecs[1] = '{3'b001, 32'h0000_00FF, 1'b0};
    vecs[2] = '{3'b010, 32'h0000_01FE, 1'b0};
    vecs[3] = '{3'b100, 32'h0000_03FC, 1'b0};
    vecs[4] = '{3'b011, 32'h0000_0101, 1'b0};
    vecs[5] = '{3'b111, 32'h0000_02FD, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    so    = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Constant scan-out patterns with hand-derived final signatures.
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c <= H; c++) so_seq[c] = vecs[i].so;
      run(i, -1, -1);
      check($sformatf("tbl%0d sig", i), 64'(sig1), 64'(vecs[i].exp_sig));
      check($sformatf("tbl%0d pass", i), 64'(pass1), 64'(vecs[i].exp_pass));
    end

    // Random scan-out; start re-pulsed while both instances are busy.
    for (int c = 0; c <= H; c++) so_seq[c] = 3'($urandom_range(0, 7));
    run(10, 6, -1);
    // Restart from DONE with the same stream: identical expectations.
    run(11, -1, -1);

    // Reset in the middle of UNLOAD (small instance), then a fresh full run.
    run(12, -1, 11);
    run(13, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
